sia_rxctl: RTL
==============

Name: sia_rxctl

Overview:
- Wishbone B4 (classic) slave controller that configures and services the SIA V.4 receive path (receiver core plus receive FIFO).
- Holds the receiver configuration registers (bits, baud, edge enables) and drives them to the receiver.
- Sequences FIFO reads as an output-enable/pop handshake, keeps sticky error status, and raises an interrupt while data is queued.

Parameters:
- SHIFT_REG_WIDTH, 16, FIFO word width; also the Wishbone data bus width (fixed at 16 in this block).
- BAUD_RATE_WIDTH, 32, baud divisor width; 17..32 supported, split into low and high 16-bit halves.
- BITS_WIDTH, 5, frame bit-count field width; must be 8 or less.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- cyc_i  in  1  Wishbone cycle
- stb_i  in  1  Wishbone strobe
- we_i  in  1  write enable
- adr_i  in  3  word address
- dat_i  in  16  write data
- dat_o  out  16  read data, registered, valid only with ack_o
- ack_o  out  1  single-cycle acknowledge
- bits_o  out  BITS_WIDTH  to receiver bits_i
- baud_o  out  BAUD_RATE_WIDTH  to receiver baud_i
- eedd_o  out  1  to receiver eedd_i
- eedc_o  out  1  to receiver eedc_i
- rxq_oe_o  out  1  FIFO output enable
- rxq_pop_o  out  1  FIFO pop, one-cycle pulse
- rxq_dat_i  in  16  FIFO head data, valid the cycle after rxq_oe_o rises
- rxq_full_i  in  1  FIFO full
- rxq_not_empty_i  in  1  FIFO not empty
- irq_o  out  1  interrupt, level, registered

Behaviour:
- A request is cyc_i&stb_i. It is sampled only in IDLE; after ack_o the FSM spends one cycle in IDLE before accepting again.
- Register map:
  - 0 RXDAT (R): pops the FIFO head. Writes are acked and ignored.
  - 1 STATUS (R/W1C): [0]=rxq_not_empty_i, [1]=rxq_full_i, [2]=underrun (sticky), [3]=irq_o, others 0. Writing 1 to bit 2 clears it.
  - 2 CONFIG (R/W): [BITS_WIDTH-1:0]=bits_o, [8]=eedd_o, [9]=eedc_o, [15]=ien.
  - 3 BAUDLO (R/W): staging register. Write does not change baud_o. Read returns the staged value.
  - 4 BAUDHI (R/W): a write loads baud_o = {dat_i[BAUD_RATE_WIDTH-17:0], staged low} atomically in one cycle. Read returns baud_o high bits, zero-extended.
  - 5..7: reads return 0, writes are ignored, both acked.
- FSM states: IDLE, RACK, DRD, DACK.
  - IDLE -> RACK: any request except a read of address 0 with rxq_not_empty_i=1. Also applies to RXDAT read when empty: dat_o=0, underrun set, no oe/pop.
  - RACK: ack_o=1; perform the write or load dat_o. Register access latency is 1 cycle. Next state IDLE.
  - IDLE -> DRD: read of address 0 with rxq_not_empty_i=1. In DRD, rxq_oe_o=1 and rxq_dat_i is captured.
  - DRD -> DACK: if cyc_i is still 1. If cyc_i=0, abort: no pop, no ack, go to IDLE.
  - DACK: ack_o=1, rxq_pop_o=1, dat_o holds the captured word. Data read latency is 2 cycles. Next state IDLE.
- rxq_oe_o is high in DRD and DACK only.
- Underrun set and W1C clear in the same cycle: set wins.
- irq_o = ien & rxq_not_empty_i, registered (1-cycle lag). Clears on the cycle after the last pop empties the FIFO.
- CONFIG writes take effect on the cycle after ack. Unused CONFIG bits read 0.
- Reset (asynchronous, any state, including mid-read): FSM=IDLE; ack_o, rxq_oe_o, rxq_pop_o, irq_o, dat_o all 0; bits_o=0, baud_o=0, staged low=0, eedd_o=eedc_o=0 (receiver disabled), ien=0, underrun=0. An interrupted read performs no pop.

Optional Feature:
- Macro: SIA_RXCTL_STALL_EN.
- Defined: an RXDAT read while the FIFO is empty enters state DWAIT instead of RACK. It holds without ack until rxq_not_empty_i=1 (-> DRD) or cyc_i=0 (-> IDLE, no ack). Underrun is never set.
- Undefined: empty read returns 0, sets underrun, and acks in 1 cycle; no DWAIT state exists.

Test Plan:
- Reset: after release, read CONFIG, BAUDLO, BAUDHI, STATUS -> all 0, irq_o=0, eedd_o=eedc_o=0.
- Baud commit: write BAUDLO=0x1234 -> baud_o stays 0. Then write BAUDHI=0x0001 -> baud_o=0x00011234 one cycle after ack.
- FIFO read: not_empty=1, rxq_dat_i=0xA5C3, read addr 0 -> rxq_oe_o high 2 cycles, ack_o and rxq_pop_o together 2 cycles after request, single pop, dat_o=0xA5C3.
- Underrun: empty FIFO, read addr 0 -> dat_o=0, no oe/pop, STATUS=0x0004. Write STATUS=0x0004 -> STATUS=0x0000.
- Interrupt: write CONFIG=0x8308 -> bits_o=8, eedd_o=eedc_o=1. Set not_empty=1 -> irq_o=1 next cycle. Pop the last word -> irq_o=0.
- Abort: drop cyc_i in DRD -> no ack, no pop. Assert reset_i low mid-DACK -> ack_o and pop drop immediately.

Source files
------------

// File: rtl/sia_rxctl.sv
// sia_rxctl: Wishbone B4 classic slave controller for the SIA V.4 receive path.
// Optional build macro SIA_RXCTL_STALL_EN: empty RXDAT reads stall in DWAIT instead of flagging underrun.
`default_nettype none

module sia_rxctl #(
  parameter int SHIFT_REG_WIDTH = 16,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int BITS_WIDTH      = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       cyc_i,
  input  logic                       stb_i,
  input  logic                       we_i,
  input  logic [2:0]                 adr_i,
  input  logic [SHIFT_REG_WIDTH-1:0] dat_i,
  output logic [SHIFT_REG_WIDTH-1:0] dat_o,
  output logic                       ack_o,
  output logic [BITS_WIDTH-1:0]      bits_o,
  output logic [BAUD_RATE_WIDTH-1:0] baud_o,
  output logic                       eedd_o,
  output logic                       eedc_o,
  output logic                       rxq_oe_o,
  output logic                       rxq_pop_o,
  input  logic [SHIFT_REG_WIDTH-1:0] rxq_dat_i,
  input  logic                       rxq_full_i,
  input  logic                       rxq_not_empty_i,
  output logic                       irq_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RACK  = 3'd1;
  localparam logic [2:0] S_DRD   = 3'd2;
  localparam logic [2:0] S_DACK  = 3'd3;
`ifdef SIA_RXCTL_STALL_EN
  localparam logic [2:0] S_DWAIT = 3'd4;
`endif

  localparam logic [2:0] A_RXDAT  = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_CONFIG = 3'd2;
  localparam logic [2:0] A_BAUDLO = 3'd3;
  localparam logic [2:0] A_BAUDHI = 3'd4;

  logic [2:0]                 state;
  logic [2:0]                 state_nxt;
  logic                       req_we;
  logic [2:0]                 req_adr;
  logic                       ien;
  logic                       underrun;
  logic [15:0]                baud_lo;
  logic [SHIFT_REG_WIDTH-1:0] rd_mux;
  logic [SHIFT_REG_WIDTH-1:0] cfg_rd;
  logic [SHIFT_REG_WIDTH-1:0] baud_hi_rd;
  logic                       req;
  logic                       fifo_rd;
  logic                       reg_wr;
  logic                       underrun_set;
  logic                       underrun_clr;

  assign req     = cyc_i & stb_i;
  assign fifo_rd = req & ~we_i & (adr_i == A_RXDAT);
  assign reg_wr  = (state == S_RACK) & req_we;

  assign ack_o     = (state == S_RACK) | (state == S_DACK);
  assign rxq_oe_o  = (state == S_DRD)  | (state == S_DACK);
  assign rxq_pop_o = (state == S_DACK);

`ifdef SIA_RXCTL_STALL_EN
  assign underrun_set = 1'b0;
`else
  assign underrun_set = (state == S_IDLE) & fifo_rd & ~rxq_not_empty_i;
`endif
  assign underrun_clr = reg_wr & (req_adr == A_STATUS) & dat_i[2];

  always_comb begin
    cfg_rd                 = '0;
    cfg_rd[BITS_WIDTH-1:0] = bits_o;
    cfg_rd[8]              = eedd_o;
    cfg_rd[9]              = eedc_o;
    cfg_rd[15]             = ien;
  end

  // Upper baud bits, zero-extended when the divisor is narrower than 32 bits
  always_comb begin
    baud_hi_rd                      = '0;
    baud_hi_rd[BAUD_RATE_WIDTH-17:0] = baud_o[BAUD_RATE_WIDTH-1:16];
  end

  always_comb begin
    rd_mux = '0;
    case (adr_i)
      A_STATUS: rd_mux[3:0] = {irq_o, underrun, rxq_full_i, rxq_not_empty_i};
      A_CONFIG: rd_mux      = cfg_rd;
      A_BAUDLO: rd_mux      = baud_lo;
      A_BAUDHI: rd_mux      = baud_hi_rd;
      default:  rd_mux      = '0;
    endcase
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (!req)
          state_nxt = S_IDLE;
        else if (fifo_rd && rxq_not_empty_i)
          state_nxt = S_DRD;
`ifdef SIA_RXCTL_STALL_EN
        else if (fifo_rd)
          state_nxt = S_DWAIT;
`endif
        else
          state_nxt = S_RACK;
      end
      S_RACK: state_nxt = S_IDLE;
      S_DRD:  state_nxt = cyc_i ? S_DACK : S_IDLE;
      S_DACK: state_nxt = S_IDLE;
`ifdef SIA_RXCTL_STALL_EN
      S_DWAIT: begin
        if (!cyc_i)
          state_nxt = S_IDLE;
        else if (rxq_not_empty_i)
          state_nxt = S_DRD;
        else
          state_nxt = S_DWAIT;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= S_IDLE;
      req_we   <= 1'b0;
      req_adr  <= '0;
      dat_o    <= '0;
      bits_o   <= '0;
      baud_o   <= '0;
      baud_lo  <= '0;
      eedd_o   <= 1'b0;
      eedc_o   <= 1'b0;
      ien      <= 1'b0;
      underrun <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      state <= state_nxt;
      irq_o <= ien & rxq_not_empty_i;

      if (state == S_IDLE && req) begin
        req_we  <= we_i;
        req_adr <= adr_i;
        if (state_nxt == S_RACK && !we_i)
          dat_o <= rd_mux;
      end

      if (state == S_DRD && cyc_i)
        dat_o <= rxq_dat_i;

      // Set has priority over a simultaneous write-one-to-clear
      if (underrun_set)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;

      // Writes commit at the end of the ack cycle, so they are visible the cycle after ack
      if (reg_wr) begin
        case (req_adr)
          A_CONFIG: begin
            bits_o <= dat_i[BITS_WIDTH-1:0];
            eedd_o <= dat_i[8];
            eedc_o <= dat_i[9];
            ien    <= dat_i[15];
          end
          A_BAUDLO: baud_lo <= dat_i;
          A_BAUDHI: baud_o  <= {dat_i[BAUD_RATE_WIDTH-17:0], baud_lo};
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
